// File: rtl/piano_pkg.sv
// Shared constants and types for the two-voice piano scheduler.
package piano_pkg;

    localparam int NKEYS    = 8;
    localparam int ADDR_W   = 16;
    localparam int NOTE_LEN = 4096;
    localparam int DEB_CYC  = 4;

    localparam int KEY_W = $clog2(NKEYS);
    localparam int OFF_W = $clog2(NOTE_LEN);

    typedef enum logic [1:0] {
        IDLE,
        SLOT0,
        SLOT1
    } sched_state_t;

    typedef struct packed {
        logic             active;
        logic [KEY_W-1:0] key;
        logic [OFF_W-1:0] off;
    } voice_t;

endpackage

// File: rtl/voice_scheduler_if.sv
// Key inputs and voice/ROM outputs of the piano voice scheduler.
interface voice_scheduler_if #(
    parameter int NKEYS  = piano_pkg::NKEYS,
    parameter int ADDR_W = piano_pkg::ADDR_W
);

    logic [NKEYS-1:0]  b;
    logic [2:0]        first;
    logic [2:0]        second;
    logic [1:0]        sel;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_voice;

    modport master (
        output b,
        input  first, second, sel, rom_en, rom_addr, rom_voice
    );

    modport slave (
        input  b,
        output first, second, sel, rom_en, rom_addr, rom_voice
    );

endinterface

// File: rtl/voice_scheduler_debouncer.sv
// Two-flop synchronizer plus per-key stability counter; a level is accepted
// only after DEB_CYC consecutive equal synchronized samples.
module key_debouncer #(
    parameter int NKEYS   = piano_pkg::NKEYS,
    parameter int DEB_CYC = piano_pkg::DEB_CYC
) (
    input  logic             LRCLK,
    input  logic             rst,
    input  logic [NKEYS-1:0] b,
    output logic [NKEYS-1:0] keys
);

    localparam int CNT_W = $clog2(DEB_CYC + 1);

    logic [NKEYS-1:0] sync1;
    logic [NKEYS-1:0] sync2;
    logic [CNT_W-1:0] cnt [NKEYS];

    always_ff @(posedge LRCLK) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            keys  <= '0;
            for (int unsigned i = 0; i < NKEYS; i++) cnt[i] <= '0;
        end else begin
            sync1 <= b;
            sync2 <= sync1;
            for (int unsigned i = 0; i < NKEYS; i++) begin
                if (sync2[i] == keys[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEB_CYC - 1)) begin
                    keys[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/voice_scheduler.sv
// Two-voice key allocator and time-shared sample-ROM address sequencer.
module voice_scheduler
    import piano_pkg::*;
#(
    parameter int NKEYS    = piano_pkg::NKEYS,
    parameter int ADDR_W   = piano_pkg::ADDR_W,
    parameter int NOTE_LEN = piano_pkg::NOTE_LEN,
    parameter int DEB_CYC  = piano_pkg::DEB_CYC
) (
    input  logic               LRCLK,
    input  logic               rst,
    voice_scheduler_if.slave   bus
);

    localparam int KW = $clog2(NKEYS);
    localparam int OW = $clog2(NOTE_LEN);

    logic [NKEYS-1:0]  keys;
    logic [NKEYS-1:0]  owned;
    logic [NKEYS-1:0]  pending;
    logic              found;
    logic [KW-1:0]     win;
    logic              any_active;

    voice_t            voice   [2];
    voice_t            voice_n [2];
    sched_state_t      state, state_n;
    logic              rom_en_q, rom_en_n;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_n;
    logic              rom_voice_q, rom_voice_n;

    key_debouncer #(.NKEYS(NKEYS), .DEB_CYC(DEB_CYC)) u_deb (
        .LRCLK (LRCLK),
        .rst   (rst),
        .b     (bus.b),
        .keys  (keys)
    );

    assign any_active    = voice[0].active | voice[1].active;
    assign bus.first     = voice[0].key;
    assign bus.second    = voice[1].key;
    assign bus.sel       = {voice[1].active, voice[0].active};
    assign bus.rom_en    = rom_en_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rom_voice = rom_voice_q;

    always_comb begin
        voice_n     = voice;
        state_n     = state;
        rom_en_n    = 1'b0;
        rom_addr_n  = rom_addr_q;
        rom_voice_n = rom_voice_q;
        owned       = '0;
        found       = 1'b0;
        win         = '0;

        for (int unsigned s = 0; s < 2; s++)
            if (voice[s].active) owned[voice[s].key] = 1'b1;
        pending = keys & ~owned;
        for (int unsigned i = 0; i < NKEYS; i++) begin
            if (!found && pending[i]) begin
                found = 1'b1;
                win   = KW'(i);
            end
        end

        for (int unsigned s = 0; s < 2; s++)
            if (voice[s].active && !keys[voice[s].key]) voice_n[s].active = 1'b0;

        case (state)
            IDLE: if (any_active) state_n = SLOT0;
            SLOT0: begin
                if (voice[0].active) begin
                    rom_en_n       = 1'b1;
                    rom_voice_n    = 1'b0;
                    rom_addr_n     = ADDR_W'({voice[0].key, voice[0].off});
                    voice_n[0].off = voice[0].off + OW'(1);
                end
                state_n = any_active ? SLOT1 : IDLE;
            end
            SLOT1: begin
                if (voice[1].active) begin
                    rom_en_n       = 1'b1;
                    rom_voice_n    = 1'b1;
                    rom_addr_n     = ADDR_W'({voice[1].key, voice[1].off});
                    voice_n[1].off = voice[1].off + OW'(1);
                end
                state_n = any_active ? SLOT0 : IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Free-slot test uses pre-release occupancy, so a slot freed here is reused next cycle.
        if (found) begin
            if (!voice[0].active)      voice_n[0] = '{active: 1'b1, key: win, off: '0};
            else if (!voice[1].active) voice_n[1] = '{active: 1'b1, key: win, off: '0};
        end
    end

    always_ff @(posedge LRCLK) begin
        if (!rst) begin
            voice[0]    <= '0;
            voice[1]    <= '0;
            state       <= IDLE;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_voice_q <= 1'b0;
        end else begin
            voice[0]    <= voice_n[0];
            voice[1]    <= voice_n[1];
            state       <= state_n;
            rom_en_q    <= rom_en_n;
            rom_addr_q  <= rom_addr_n;
            rom_voice_q <= rom_voice_n;
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: allocation, release, ROM addressing, reset, debounce.
module tb_voice_scheduler;
    import piano_pkg::*;

    logic LRCLK = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    voice_scheduler_if bus ();

    voice_scheduler dut (
        .LRCLK (LRCLK),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 LRCLK = ~LRCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge LRCLK);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},   32'(bus.sel), 0);
        check({tag, "_first"}, 32'(bus.first), 0);
        check({tag, "_second"},32'(bus.second), 0);
        check({tag, "_en"},    32'(bus.rom_en), 0);
        check({tag, "_addr"},  32'(bus.rom_addr), 0);
        check({tag, "_voice"}, 32'(bus.rom_voice), 0);
        check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
    endtask

    initial begin
        logic found_rd;
        rst   = 1'b0;
        bus.b = '0;
        step(3);
        check_all_zero("por");

        // single key 2: bound after 7 cycles, reads every other cycle from 8192
        rst   = 1'b1;
        bus.b = 8'h04;
        step(6);
        check("t2_sel_pre", 32'(bus.sel), 0);
        step(1);
        check("t2_sel", 32'(bus.sel), 1);
        check("t2_first", 32'(bus.first), 2);
        step(1);
        check("t2_en_idle", 32'(bus.rom_en), 0);
        step(1);
        check("t2_en0", 32'(bus.rom_en), 1);
        check("t2_addr0", 32'(bus.rom_addr), 8192);
        check("t2_voice0", 32'(bus.rom_voice), 0);
        step(1);
        check("t2_en_gap", 32'(bus.rom_en), 0);
        step(1);
        check("t2_addr1", 32'(bus.rom_addr), 8193);
        step(8188);
        check("t2_en_last", 32'(bus.rom_en), 1);
        check("t2_addr_last", 32'(bus.rom_addr), 12287);
        step(2);
        check("t2_en_wrap", 32'(bus.rom_en), 1);
        check("t2_addr_wrap", 32'(bus.rom_addr), 8192);

        // reset mid-play
        bus.b = '0;
        rst   = 1'b0;
        step(1);
        check_all_zero("t1a");
        step(2);
        check_all_zero("t1b");
        rst = 1'b1;

        // keys 0 and 7 together: key0 first, key7 one cycle later
        bus.b = 8'h81;
        step(7);
        check("t3_sel1", 32'(bus.sel), 1);
        check("t3_first", 32'(bus.first), 0);
        step(1);
        check("t3_sel3", 32'(bus.sel), 3);
        check("t3_second", 32'(bus.second), 7);
        step(1);
        check("t3_rd0", {bus.rom_en, bus.rom_voice, 16'(bus.rom_addr)}, {1'b1, 1'b0, 16'd0});
        step(1);
        check("t3_rd1", {bus.rom_en, bus.rom_voice, 16'(bus.rom_addr)}, {1'b1, 1'b1, 16'd28672});
        step(1);
        check("t3_rd2", {bus.rom_en, bus.rom_voice, 16'(bus.rom_addr)}, {1'b1, 1'b0, 16'd1});
        step(1);
        check("t3_rd3", {bus.rom_en, bus.rom_voice, 16'(bus.rom_addr)}, {1'b1, 1'b1, 16'd28673});

        // release all
        bus.b = '0;
        step(6);
        check("t6_sel_pre", 32'(bus.sel), 3);
        step(1);
        check("t6_sel", 32'(bus.sel), 0);
        step(2);
        check("t6_state", 32'(dut.state), 32'(IDLE));
        for (int i = 0; i < 4; i++) begin
            check("t6_en", 32'(bus.rom_en), 0);
            step(1);
        end

        // keys 1,3 held, key5 ignored, release key1 -> key5 takes voice0
        bus.b = 8'h0A;
        step(7);
        check("t4_sel1", 32'(bus.sel), 1);
        check("t4_first", 32'(bus.first), 1);
        step(1);
        check("t4_sel3", 32'(bus.sel), 3);
        check("t4_second", 32'(bus.second), 3);
        bus.b = 8'h2A;
        step(8);
        check("t4_full_sel", 32'(bus.sel), 3);
        check("t4_full_keys", {bus.first, bus.second}, {3'd1, 3'd3});
        bus.b = 8'h28;
        step(6);
        check("t4_rel_pre", 32'(bus.sel), 3);
        step(1);
        check("t4_rel_sel", 32'(bus.sel), 2);
        step(1);
        check("t4_realloc_sel", 32'(bus.sel), 3);
        check("t4_realloc_first", 32'(bus.first), 5);
        found_rd = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (bus.rom_en && !bus.rom_voice) begin
                found_rd = 1'b1;
                break;
            end
        end
        check("t4_rd_seen", 32'(found_rd), 1);
        check("t4_rd_addr", 32'(bus.rom_addr), 20480);
        bus.b = '0;
        step(12);
        check("t4_end_sel", 32'(bus.sel), 0);
        check("t4_end_en", 32'(bus.rom_en), 0);

        // 3-cycle glitch on key 6 must be rejected
        bus.b = 8'h40;
        step(3);
        bus.b = '0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            check("t5_quiet", {bus.sel, bus.rom_en}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
